// File: rtl/helloworld_nios2_gen2_0_cpu_div_cell.sv
// ---------------------------------------------------------------------------
// helloworld_nios2_gen2_0_cpu_div_cell
//
// Iterative radix-2 restoring divider for DIV/DIVU. One operation is
// accepted per start pulse while idle. Operands are converted to
// magnitudes, divided over DATA_W shift-subtract steps, and then sign-fixed.
// The quotient and remainder are registered when the result is presented.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous, active-low reset
//   start        launch request; only honoured in IDLE
//   is_signed    1 = DIV (two's complement), 0 = DIVU; captured with start
//   dividend     numerator; captured with start
//   divisor      denominator; captured with start
//   kill         flush; abandons any in-flight operation
//   busy         high in every state except IDLE
//   done         one-cycle pulse; results are valid in that cycle
//   quotient     result quotient; holds until the next done
//   remainder    result remainder; has the same sign as the dividend when signed
//   div_by_zero  qualifies done: the divisor was zero
// ---------------------------------------------------------------------------
module helloworld_nios2_gen2_0_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [DATA_W-1:0]  dividend_reg;   // raw operand; returned as remainder on divide-by-zero
  logic [DATA_W-1:0]  divisor_reg;
  logic               signed_reg;
  logic [DATA_W-1:0]  rem_reg;
  logic [DATA_W-1:0]  quo_reg;        // holds |dividend| and shifts quotient bits in from the right
  logic [DATA_W-1:0]  div_abs_reg;
  logic               q_neg_reg;
  logic               r_neg_reg;
  logic               done_reg;
  logic [DATA_W-1:0]  quotient_reg;
  logic [DATA_W-1:0]  remainder_reg;
  logic               div_by_zero_reg;

  // Operand magnitudes (only negated for signed operations).
  logic               a_neg;
  logic               b_neg;
  logic [DATA_W-1:0]  a_abs;
  logic [DATA_W-1:0]  b_abs;

  // One restoring step. The remainder is always below the divisor, so the
  // shifted remainder fits in DATA_W+1 bits and so does the subtraction.
  logic [DATA_W:0]    rem_shift;
  logic [DATA_W:0]    rem_diff;
  logic               take_sub;
  logic [DATA_W-1:0]  rem_step;
  logic [DATA_W-1:0]  quo_step;

  always_comb begin
    a_neg     = signed_reg & dividend_reg[DATA_W-1];
    b_neg     = signed_reg & divisor_reg[DATA_W-1];
    a_abs     = a_neg ? (-dividend_reg) : dividend_reg;
    b_abs     = b_neg ? (-divisor_reg)  : divisor_reg;

    rem_shift = {rem_reg, quo_reg[DATA_W-1]};
    rem_diff  = rem_shift - {1'b0, div_abs_reg};
    take_sub  = (rem_shift >= {1'b0, div_abs_reg});
    rem_step  = take_sub ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    quo_step  = {quo_reg[DATA_W-2:0], take_sub};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      dividend_reg    <= '0;
      divisor_reg     <= '0;
      signed_reg      <= 1'b0;
      rem_reg         <= '0;
      quo_reg         <= '0;
      div_abs_reg     <= '0;
      q_neg_reg       <= 1'b0;
      r_neg_reg       <= 1'b0;
      done_reg        <= 1'b0;
      quotient_reg    <= '0;
      remainder_reg   <= '0;
      div_by_zero_reg <= 1'b0;
    end else if (kill) begin
      // Flush: results from earlier operations stay visible.
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            signed_reg   <= is_signed;
            state_reg    <= PREP;
          end
        end

        PREP: begin
          if (divisor_reg == '0) begin
            // Short-circuit: no iterations, result presented next cycle.
            quotient_reg    <= '1;
            remainder_reg   <= dividend_reg;
            div_by_zero_reg <= 1'b1;
            done_reg        <= 1'b1;
            state_reg       <= DONE;
          end else begin
            rem_reg     <= '0;
            quo_reg     <= a_abs;
            div_abs_reg <= b_abs;
            q_neg_reg   <= a_neg ^ b_neg;
            r_neg_reg   <= a_neg;
            count_reg   <= CNT_W'(DATA_W - 1);
            state_reg   <= ITER;
          end
        end

        ITER: begin
          rem_reg   <= rem_step;
          quo_reg   <= quo_step;
          count_reg <= count_reg - CNT_W'(1);
          if (count_reg == '0) begin
            state_reg <= FIX;
          end
        end

        FIX: begin
          // -2^(W-1) / -1 yields magnitude 2^(W-1), which wraps to itself.
          quotient_reg    <= q_neg_reg ? (-quo_reg) : quo_reg;
          remainder_reg   <= r_neg_reg ? (-rem_reg) : rem_reg;
          div_by_zero_reg <= 1'b0;
          done_reg        <= 1'b1;
          state_reg       <= DONE;
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_helloworld_nios2_gen2_0_cpu_div_cell.sv
module tb_helloworld_nios2_gen2_0_cpu_div_cell;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         kill;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  helloworld_nios2_gen2_0_cpu_div_cell #(.DATA_W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .kill        (kill),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain language arithmetic plus the divide-by-zero rule.
  function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (s) begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  // Issue one operation and wait for its done pulse. Returns in the cycle
  // after done (the first cycle a new start can be accepted).
  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat, output int busy_cnt, output bit timed_out);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
    q = '0; r = '0; z = 1'b0; lat = 0; busy_cnt = 0; timed_out = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c; q = quotient; r = remainder; z = div_by_zero; timed_out = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    if (!timed_out) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; kill = 1'b0; is_signed = 1'b0; dividend = '1; divisor = '1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (quotient !== '0) begin miscompares++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    vectors++; if (remainder !== '0) begin miscompares++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit           s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } dcase_t;

  task automatic test_directed();
    dcase_t tbl[8];
    logic [W-1:0] q, r;
    logic z;
    int lat, bc;
    bit to;
    tbl[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    tbl[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    tbl[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    tbl[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0};
    tbl[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0};
    tbl[5] = '{1'b0, 32'h12345678,   32'd1000,     32'h0004A90B, 32'h00000380};
    tbl[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    tbl[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000};
    foreach (tbl[i]) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, q, r, z, lat, bc, to);
      $display("directed %0d: s=%0d %h/%h -> q=%h r=%h z=%b lat=%0d", i, tbl[i].s, tbl[i].a, tbl[i].b, q, r, z, lat);
      vectors++; if (to) begin miscompares++; $display("FAIL directed_timeout[%0d]: no done within 100 cycles", i); end
      vectors++; if (q !== tbl[i].q) begin miscompares++; $display("FAIL directed_q[%0d]: got %h expected %h", i, q, tbl[i].q); end
      vectors++; if (r !== tbl[i].r) begin miscompares++; $display("FAIL directed_r[%0d]: got %h expected %h", i, r, tbl[i].r); end
      vectors++; if (z !== 1'b0) begin miscompares++; $display("FAIL directed_dbz[%0d]: got %b expected 0", i, z); end
      vectors++; if (lat != W + 3) begin miscompares++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, W + 3); end
      if (i == 0) begin
        vectors++; if (bc != W + 2) begin miscompares++; $display("FAIL busy_cycles: got %0d expected %0d", bc, W + 2); end
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r;
    logic z;
    int lat, bc;
    bit to;
    run_op(1'b0, 32'd5, 32'd0, q, r, z, lat, bc, to);
    $display("dbz divu 5/0 -> q=%h r=%h z=%b lat=%0d", q, r, z, lat);
    vectors++; if (lat != 2) begin miscompares++; $display("FAIL dbz_latency: got %0d expected 2", lat); end
    vectors++; if (q !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dbz_q: got %h expected ffffffff", q); end
    vectors++; if (r !== 32'd5) begin miscompares++; $display("FAIL dbz_r: got %h expected 00000005", r); end
    vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL dbz_flag: got %b expected 1", z); end
    run_op(1'b1, 32'hFFFFFFF7, 32'd0, q, r, z, lat, bc, to);
    $display("dbz div -9/0 -> q=%h r=%h z=%b lat=%0d", q, r, z, lat);
    vectors++; if (r !== 32'hFFFFFFF7) begin miscompares++; $display("FAIL dbz_signed_r: got %h expected fffffff7", r); end
    vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL dbz_signed_flag: got %b expected 1", z); end
    run_op(1'b0, 32'd9, 32'd4, q, r, z, lat, bc, to);
    $display("after dbz divu 9/4 -> q=%h r=%h z=%b lat=%0d", q, r, z, lat);
    vectors++; if (z !== 1'b0) begin miscompares++; $display("FAIL dbz_clear: got %b expected 0", z); end
    vectors++; if (q !== 32'd2 || r !== 32'd1) begin miscompares++; $display("FAIL dbz_next_op: got q=%h r=%h expected q=2 r=1", q, r); end
  endtask

  task automatic test_kill();
    logic [W-1:0] q, r;
    logic z;
    int lat, bc;
    bit to;
    int done_seen;
    // Known prior result: 9/4 -> 2 rem 1 from the previous task.
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end   // now in cycle 11 = ITER cycle 10
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    $display("kill at iter 10 -> busy=%b", busy);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL kill_busy: got %b expected 0", busy); end
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    vectors++; if (done_seen != 0) begin miscompares++; $display("FAIL kill_no_done: got %0d dones expected 0", done_seen); end
    vectors++; if (quotient !== 32'd2 || remainder !== 32'd1) begin
      miscompares++; $display("FAIL kill_hold: got q=%h r=%h expected q=2 r=1", quotient, remainder);
    end
    run_op(1'b0, 32'd1000, 32'd3, q, r, z, lat, bc, to);
    $display("after kill divu 1000/3 -> q=%h r=%h lat=%0d", q, r, lat);
    vectors++; if (q !== 32'd333 || r !== 32'd1 || lat != W + 3) begin
      miscompares++; $display("FAIL kill_restart: got q=%h r=%h lat=%0d expected q=14d r=1 lat=%0d", q, r, lat, W + 3);
    end
  endtask

  task automatic test_back_to_back();
    int dcount;
    int dcyc[$];
    start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'hFFFFFFF9;
    @(posedge clk); #1;
    dcount = 0;
    for (int c = 1; c <= 3 * (W + 4) - 1; c++) begin
      if (done) begin
        dcount++;
        dcyc.push_back(c);
        $display("back_to_back done at cycle %0d q=%h r=%h", c, quotient, remainder);
        vectors++; if (quotient !== 32'hFFFFFF72 || remainder !== 32'd6) begin
          miscompares++; $display("FAIL b2b_result: got q=%h r=%h expected q=ffffff72 r=6", quotient, remainder);
        end
      end
      if (c < 3 * (W + 4) - 1) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    vectors++; if (dcount != 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", dcount); end
    if (dcyc.size() == 3) begin
      vectors++; if (dcyc[1] - dcyc[0] != W + 4 || dcyc[2] - dcyc[1] != W + 4) begin
        miscompares++; $display("FAIL b2b_spacing: got %0d,%0d expected %0d", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1], W + 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    $display("reset mid-iter -> busy=%b done=%b q=%h r=%h z=%b", busy, done, quotient, remainder, div_by_zero);
    vectors++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      miscompares++; $display("FAIL midreset_ctrl: got busy=%b done=%b z=%b expected 0 0 0", busy, done, div_by_zero);
    end
    vectors++; if (quotient !== '0 || remainder !== '0) begin
      miscompares++; $display("FAIL midreset_data: got q=%h r=%h expected 0 0", quotient, remainder);
    end
    reset_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    vectors++; if (done_seen != 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d expected 0", done_seen); end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] a, b, q, r, eq, er;
    logic z, ez;
    int lat, bc;
    bit to, s;
    for (int i = 0; i < n; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1:       b = 32'hFFFFFFFF;
        2, 3:    b = $urandom_range(1, 16);
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h80000000;
      ref_div(s, a, b, eq, er, ez);
      run_op(s, a, b, q, r, z, lat, bc, to);
      $display("rand %0d: s=%0d %h/%h -> q=%h r=%h z=%b lat=%0d", i, s, a, b, q, r, z, lat);
      vectors++; if (to || q !== eq || r !== er || z !== ez) begin
        miscompares++;
        $display("FAIL rand_result[%0d]: got q=%h r=%h z=%b to=%0d expected q=%h r=%h z=%b", i, q, r, z, to, eq, er, ez);
      end
      vectors++; if (lat != (ez ? 2 : W + 3)) begin
        miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, ez ? 2 : W + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_random(1000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
